// File: rtl/tiny_dnn_regfile.sv
// tiny_dnn_regfile: AXI4-Lite slave register file for the tiny-dnn accelerator.
// Register 0 is control/status and registers 1..NREG-1 are 32-bit config words.
// Handshake rule on every AXI channel: a beat transfers on a rising clock edge
// where VALID and READY are both high. A VALID, once raised by this block
// (BVALID/RVALID), stays high with stable payload until the matching READY.
// The READY outputs are decoded from the FSM state, and ARREADY also looks at
// AWVALID/WVALID. Because of that, a write offered in the same cycle as a read
// always goes first.
module tiny_dnn_regfile #(
  parameter int NREG = 16,
  parameter int AW   = 10
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  input  logic [AW-1:0]            S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [AW-1:0]            S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic                     src_ready,
  input  logic                     busy_i,
  input  logic                     done_i,
  output logic                     start_o,
  output logic [7:0]               mode_o,
  output logic                     irq_o,
  output logic [32*(NREG-1)-1:0]   cfg_o,
  output logic [2:0]               dbg_state_o
);

  localparam int          IW     = AW - 2;
  localparam logic [31:0] NREG_U = 32'(NREG);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    COMMIT  = 3'd3,
    BRESP   = 3'd4,
    RRESP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   cfg_q [1:NREG-1];
  logic          irq_en_q, done_q, start_q, irq_q;
  logic [7:0]    mode_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q, bresp_q;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic          w_in_range, r_in_range, w_reg0, done_clr;
  logic [31:0]   widx32, ridx32;
  logic [31:0]   reg0_rd, rd_mux;
  logic          unused_addr_bits;

  // The two low address bits only select a byte inside a word.
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (state_q == IDLE) || (state_q == WAIT_AW);
  assign S_AXI_WREADY  = (state_q == IDLE) || (state_q == WAIT_W);
  assign S_AXI_ARREADY = (state_q == IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = (state_q == COMMIT);

  assign widx32     = {{(32-IW){1'b0}}, widx_q};
  assign ridx32     = {{(32-IW){1'b0}}, S_AXI_ARADDR[AW-1:2]};
  assign w_in_range = (widx32 < NREG_U);
  assign r_in_range = (ridx32 < NREG_U);
  assign w_reg0     = commit && (widx32 == 32'd0);
  assign done_clr   = w_reg0 && wstrb_q[0] && wdata_q[2];

  assign reg0_rd = {src_ready, 15'b0, mode_q, 4'b0, busy_i, done_q, irq_en_q, 1'b0};

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic: writes take priority over reads when leaving IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID) state_d = COMMIT;
        else if (S_AXI_AWVALID)            state_d = WAIT_W;
        else if (S_AXI_WVALID)             state_d = WAIT_AW;
        else if (S_AXI_ARVALID)            state_d = RRESP;
      end
      WAIT_W:  if (S_AXI_WVALID)  state_d = COMMIT;
      WAIT_AW: if (S_AXI_AWVALID) state_d = COMMIT;
      COMMIT:  state_d = BRESP;
      BRESP:   if (S_AXI_BREADY)  state_d = IDLE;
      RRESP:   if (S_AXI_RREADY)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold the write address index and data until both halves have arrived.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      widx_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) widx_q <= S_AXI_AWADDR[AW-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file update at the end of COMMIT, plus the start/done/irq side effects.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int k = 1; k < NREG; k++) cfg_q[k] <= '0;
      irq_en_q <= 1'b0;
      mode_q   <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      // A start request while the accelerator is busy is silently dropped.
      start_q <= w_reg0 && wstrb_q[0] && wdata_q[0] && !busy_i;
      irq_q   <= done_q && irq_en_q;
      // A completion arriving in the same cycle as a clear must not be lost.
      if (done_i)        done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      if (w_reg0 && wstrb_q[0]) irq_en_q <= wdata_q[1];
      if (w_reg0 && wstrb_q[1]) mode_q   <= wdata_q[15:8];
      for (int k = 1; k < NREG; k++) begin
        if (commit && (widx32 == 32'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) cfg_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
      if (commit) bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read mux over the register file, indexed straight from ARADDR.
  always_comb begin
    rd_mux = '0;
    if (ridx32 == 32'd0) rd_mux = reg0_rd;
    for (int k = 1; k < NREG; k++) begin
      if (ridx32 == 32'(k)) rd_mux = cfg_q[k];
    end
  end

  // Read data and response are captured when AR is accepted and held through RRESP.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= r_in_range ? rd_mux : 32'h0;
      rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Flatten config registers: register k occupies bits [32k-1:32(k-1)].
  always_comb begin
    cfg_o = '0;
    for (int k = 1; k < NREG; k++) cfg_o[32*(k-1) +: 32] = cfg_q[k];
  end

  assign S_AXI_BVALID = (state_q == BRESP);
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = (state_q == RRESP);
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign start_o      = start_q;
  assign irq_o        = irq_q;
  assign mode_o       = mode_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/tiny_dnn_regfile.md
Name: tiny_dnn_regfile

Overview:
- Parametrised AXI4-Lite slave register file for the tiny-dnn accelerator; next generation of the fixed 16-entry control block.
- Adds a configurable register count, WSTRB byte masking, SLVERR on out-of-range addresses, a self-clearing start pulse, a sticky write-1-to-clear done flag and an interrupt output.
- Sits between the PS AXI-Lite master and the accelerator datapath/DMA sequencer.

Parameters:
- NREG, 16, number of 32-bit registers; index 0 is control/status, 1..NREG-1 are config. Range 2..256.
- AW, 10, AXI address width used; register index = ADDR[AW-1:2].

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  synchronous active-high reset
- S_AXI_AWADDR  in  AW  write address
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  AW  read address
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  32  read data, registered
- S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
- src_ready  in  1  datapath ready status
- busy_i  in  1  accelerator running
- done_i  in  1  one-cycle completion pulse
- start_o  out  1  one-cycle start pulse
- mode_o  out  8  reg0 bits[15:8] (pool,last,deltaw,backprop,enbias,run,wwrite,bwrite, MSB first)
- irq_o  out  1  done & irq_en, registered
- cfg_o  out  32*(NREG-1)  config regs flattened; reg k at bits [32k-1:32(k-1)]

Behaviour:
- Reset: all registers 0; all VALID outputs 0; RDATA 0; start_o/irq_o 0; FSM to IDLE. Reset mid-transaction discards the transaction; no partial write.
- FSM states: IDLE, WAIT_W, WAIT_AW, COMMIT, BRESP, RRESP.
- AWREADY is high in IDLE and WAIT_AW. WREADY is high in IDLE and WAIT_W. ARREADY is high in IDLE only when AWVALID and WVALID are both low, so writes win simultaneous requests.
- Transitions out of IDLE:
  - AW&W -> COMMIT.
  - AW only -> WAIT_W.
  - W only -> WAIT_AW.
  - AR -> RRESP.
- WAIT_W +W -> COMMIT. WAIT_AW +AW -> COMMIT.
- COMMIT (exactly 1 cycle): register updated at end of this cycle -> BRESP. BVALID is asserted the cycle after COMMIT and held until BREADY; then IDLE.
- Write latency: last of AW/W accepted at edge N; register value visible at N+2; BVALID high from N+2.
- Write masking: each byte b is updated only where WSTRB[b]=1.
- Out-of-range: index >= NREG gives no register change and BRESP=10.
- Read: AR accepted at edge N; RDATA/RRESP registered at N; RVALID high from N+1, held with stable data until RREADY; then IDLE. Out-of-range read returns RDATA=0, RRESP=10.
- Reg0 layout:
  - bit0 start: W1 pulse, reads 0.
  - bit1 irq_en: RW.
  - bit2 done: sticky, W1C.
  - bit3 busy_i: RO.
  - bits[15:8] mode: RW.
  - bit31 src_ready: RO.
  - Other bits read 0.
- start_o: 1-cycle pulse in the cycle after COMMIT when the committed write hits reg0 with WSTRB[0]=1 and WDATA[0]=1 and busy_i=0. If busy_i=1 the start is dropped; the response is still OKAY and the other fields are still written.
- done: set by done_i. Cleared by W1C to bit2 with WSTRB[0]. If done_i and a clear occur in the same cycle, set wins.
- irq_o = registered (done & irq_en), so 1 cycle after the inputs change.
- Config regs: full 32-bit RW, no field truncation; the consumer slices fields.

Test Plan:
- Reset with S_AXI_ARESET=1 for 2 cycles -> every register reads 0, BVALID=RVALID=0, start_o=irq_o=0.
- Write reg5=0xDEADBEEF with AW and W in the same cycle -> BVALID at +2 cycles, BRESP=00; then write WSTRB=0010 data 0x00001100 -> read back 0xDEAD11EF, cfg_o[159:128]=0xDEAD11EF.
- Present W 3 cycles before AW, then AW/AR simultaneously in IDLE -> write completes first, AR accepted only after B handshake; with RREADY low for 4 cycles, RVALID and RDATA stay stable.
- NREG=16, write/read index 20 -> BRESP=10, RRESP=10, RDATA=0, no register changes.
- Write reg0=0x0000_2103 (start, irq_en, mode=0x21) with busy_i=0 -> single start_o pulse, mode_o=0x21; repeat with busy_i=1 -> no pulse.
- Pulse done_i -> reg0 bit2=1, irq_o=1 next cycle; W1C write to bit2 in the same cycle as a second done_i pulse -> done stays 1; a later W1C alone clears it and irq_o drops.
